planta_termica: RTL and testbench



---
 rtl/planta_if.sv | 21 ++
 rtl/planta_termica.sv | 113 +++++++++++
 tb/tb_planta_termica.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/planta_if.sv
// Actuator/sensor bundle between a temperature controller and the plant.
interface planta_if;
    logic               calefactor;
    logic               ventilador;
    logic               congelar;
    logic               carga_en;
    logic signed [10:0] carga_valor;
    logic signed [10:0] temp_salida;
    logic               tick;
    logic               saturado;

    modport master (
        output calefactor, ventilador, congelar, carga_en, carga_valor,
        input  temp_salida, tick, saturado
    );

    modport slave (
        input  calefactor, ventilador, congelar, carga_en, carga_valor,
        output temp_salida, tick, saturado
    );
endinterface

// File: rtl/planta_termica.sv
// Thermal plant emulator: integrates heater/fan commands every PASO_DIV clocks.
// Optional RUIDO_EN macro adds LFSR-driven +/-1 noise to each update.
module planta_termica #(
    parameter int PASO_DIV  = 4,
    parameter int DELTA_ACT = 2,
    parameter int TEMP_INIT = 25,
    parameter int TEMP_AMB  = 25,
    parameter int TEMP_MIN  = -40,
    parameter int TEMP_MAX  = 125
) (
    input logic     clk,
    input logic     arst_n,
    planta_if.slave bus
);
    localparam int PW = (PASO_DIV > 1) ? $clog2(PASO_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PASO_DIV - 1);
    localparam logic signed [12:0] D13   = 13'(DELTA_ACT);
    localparam logic signed [12:0] AMB13 = 13'(TEMP_AMB);
    localparam logic signed [12:0] MIN13 = 13'(TEMP_MIN);
    localparam logic signed [12:0] MAX13 = 13'(TEMP_MAX);
    localparam logic signed [10:0] INIT11 = 11'(TEMP_INIT);

    logic [PW-1:0]      presc;
    logic signed [10:0] temp;
    logic               tick_q;
    logic               sat_q;
    logic signed [12:0] t13;
    logic signed [12:0] step;
    logic signed [12:0] nxt13;
    logic signed [12:0] ld13;
    logic signed [10:0] upd_val;
    logic signed [10:0] ld_val;
    logic               upd_sat;
    logic               ld_sat;

`ifdef RUIDO_EN
    logic [7:0]         lfsr;
    logic signed [12:0] ruido;
`endif

    function automatic logic signed [10:0] clamp(input logic signed [12:0] v);
        if (v < MIN13)
            return MIN13[10:0];
        else if (v > MAX13)
            return MAX13[10:0];
        else
            return v[10:0];
    endfunction

    always_comb begin
        t13  = {{2{temp[10]}}, temp};
        ld13 = {{2{bus.carga_valor[10]}}, bus.carga_valor};
        step = '0;
        if (bus.calefactor && !bus.ventilador)
            step = D13;
        else if (bus.ventilador && !bus.calefactor)
            step = -D13;
        else if (t13 < AMB13)
            step = 13'sd1;
        else if (t13 > AMB13)
            step = -13'sd1;
`ifdef RUIDO_EN
        ruido = '0;
        unique case (lfsr[1:0])
            2'b01:   ruido = 13'sd1;
            2'b10:   ruido = -13'sd1;
            default: ruido = '0;
        endcase
        nxt13 = t13 + step + ruido;
`else
        nxt13 = t13 + step;
`endif
        upd_val = clamp(nxt13);
        upd_sat = (nxt13 < MIN13) || (nxt13 > MAX13);
        ld_val  = clamp(ld13);
        ld_sat  = (ld13 < MIN13) || (ld13 > MAX13);
    end

    // Load beats freeze, freeze beats the regular update.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc  <= '0;
            temp   <= INIT11;
            tick_q <= 1'b0;
            sat_q  <= 1'b0;
`ifdef RUIDO_EN
            lfsr   <= 8'hA5;
`endif
        end else if (bus.carga_en) begin
            presc  <= '0;
            temp   <= ld_val;
            sat_q  <= ld_sat;
            tick_q <= 1'b0;
        end else if (bus.congelar) begin
            tick_q <= 1'b0;
        end else if (presc == PLAST) begin
            presc  <= '0;
            temp   <= upd_val;
            sat_q  <= upd_sat;
            tick_q <= 1'b1;
`ifdef RUIDO_EN
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
        end else begin
            presc  <= presc + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign bus.temp_salida = temp;
    assign bus.tick        = tick_q;
    assign bus.saturado    = sat_q;
endmodule

// File: tb/tb_planta_termica.sv
// Bench for planta_termica: directed vector table, reset corner case,
// and a randomized run against an arithmetic reference model.
module tb_planta_termica;
    localparam int PASO = 4;
    localparam int DACT = 2;
    localparam int TAMB = 25;
    localparam int TMIN = -40;
    localparam int TMAX = 125;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    planta_if bus ();

    planta_termica dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit cal;
        bit ven;
        bit cong;
        bit ld;
        int val;
        int et;
        bit etk;
        bit es;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(input int n, input bit cal, input bit ven, input bit cong,
                       input bit ld, input int val, input int et, input bit etk,
                       input bit es);
        vec_t v;
        v.n = n; v.cal = cal; v.ven = ven; v.cong = cong; v.ld = ld;
        v.val = val; v.et = et; v.etk = etk; v.es = es;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit cal, input bit ven, input bit cong,
                         input bit ld, input int val);
        bus.calefactor  = cal;
        bus.ventilador  = ven;
        bus.congelar    = cong;
        bus.carga_en    = ld;
        bus.carga_valor = 11'(val);
    endtask

    task automatic check(input string name, input int et, input bit etk, input bit es);
        int got;
        got = int'(bus.temp_salida);
        n_chk++;
        if (got != et || bus.tick !== etk || bus.saturado !== es) begin
            n_fail++;
            $display("FAIL %s: got temp=%0d tick=%0b sat=%0b, want temp=%0d tick=%0b sat=%0b",
                     name, got, bus.tick, bus.saturado, et, etk, es);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < TMIN) return TMIN;
        if (v > TMAX) return TMAX;
        return v;
    endfunction

    // Reference: a plant update happens on every PASO-th unfrozen, unloaded
    // clock counted since the last load or since reset.
    int  m_t, m_act, m_sat;
    bit  m_tick;

    task automatic model_edge(input bit cal, input bit ven, input bit cong,
                              input bit ld, input int val);
        int want, raw;
        m_tick = 1'b0;
        if (ld) begin
            m_t   = clampi(val);
            m_sat = (m_t != val);
            m_act = 0;
        end else if (!cong) begin
            m_act++;
            if (m_act % PASO == 0) begin
                if (cal == ven)
                    want = (m_t < TAMB) ? m_t + 1 : (m_t > TAMB) ? m_t - 1 : m_t;
                else
                    want = cal ? m_t + DACT : m_t - DACT;
                raw    = want;
                m_t    = clampi(raw);
                m_sat  = (m_t != raw);
                m_tick = 1'b1;
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check("reset", 25, 0, 0);

        add(3, 1,0,0,0,0,    25, 0,0);
        add(1, 1,0,0,0,0,    27, 1,0);
        add(1, 1,0,0,0,0,    27, 0,0);
        add(3, 1,0,0,0,0,    29, 1,0);
        add(4, 1,0,0,0,0,    31, 1,0);
        add(1, 1,0,0,1,120,  120,0,0);
        add(4, 1,0,0,0,0,    122,1,0);
        add(4, 1,0,0,0,0,    124,1,0);
        add(4, 1,0,0,0,0,    125,1,1);
        add(4, 1,0,0,0,0,    125,1,1);
        add(1, 0,0,0,1,30,   30, 0,0);
        add(4, 0,0,0,0,0,    29, 1,0);
        add(16,0,0,0,0,0,    25, 1,0);
        add(4, 0,0,0,0,0,    25, 1,0);
        add(1, 1,1,0,1,20,   20, 0,0);
        add(4, 1,1,0,0,0,    21, 1,0);
        add(16,1,1,0,0,0,    25, 1,0);
        add(3, 0,0,0,0,0,    25, 0,0);
        add(1, 0,0,0,1,200,  125,0,1);
        add(3, 0,0,0,0,0,    125,0,1);
        add(1, 0,0,0,0,0,    124,1,0);
        add(1, 0,1,0,1,-35,  -35,0,0);
        add(4, 0,1,0,0,0,    -37,1,0);
        add(4, 0,1,0,0,0,    -39,1,0);
        add(4, 0,1,0,0,0,    -40,1,1);
        add(2, 0,1,0,0,0,    -40,0,1);
        add(10,0,1,1,0,0,    -40,0,1);
        add(1, 0,1,0,0,0,    -40,0,1);
        add(1, 0,1,0,0,0,    -40,1,1);
        add(1, 1,0,1,1,-100, -40,0,1);
        add(4, 1,0,0,0,0,    -38,1,0);

        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cal, tbl[i].ven, tbl[i].cong, tbl[i].ld, tbl[i].val);
            repeat (tbl[i].n) begin
                @(posedge clk);
                #1 drive(tbl[i].cal, tbl[i].ven, tbl[i].cong, 1'b0, tbl[i].val);
            end
            check($sformatf("vec%0d", i), tbl[i].et, tbl[i].etk, tbl[i].es);
        end

        drive(0, 0, 0, 1, 31);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0);
        check("load31", 31, 0, 0);
        repeat (2) @(posedge clk);
        #2 arst_n = 1'b0;
        #1 check("async_rst", 25, 0, 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("post_rst_notick", 25, 0, 0);
        @(posedge clk);
        #1 check("post_rst_tick", 25, 1, 0);

        m_t = 25; m_act = 0; m_sat = 0; m_tick = 0;
        for (int c = 0; c < 3000; c++) begin
            bit cal, ven, cong, ld;
            int val;
            cal  = 1'($urandom_range(0, 1));
            ven  = 1'($urandom_range(0, 1));
            cong = ($urandom_range(0, 9) == 0);
            ld   = ($urandom_range(0, 39) == 0);
            val  = int'($urandom_range(0, 2047));
            if (val > 1023) val -= 2048;
            drive(cal, ven, cong, ld, val);
            @(posedge clk);
            #1;
            model_edge(cal, ven, cong, ld, val);
            check($sformatf("rand%0d", c), m_t, m_tick, m_sat[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
